// File: rtl/ram_sum_ctrl_pkg.sv
// Shared types and constants for the RAM block summing controller.
// Imported by the interface, the accumulator and the top controller.
package ram_sum_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ram_sum_ctrl_if.sv
// Request, result and RAM port bundle of the summing controller.
// master drives requests and RAM data; slave is the controller itself.
interface ram_sum_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] base_addr;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] ram_addr;
    logic [WIDTH-1:0] ram_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] max_val;
    logic             ovf;

    modport master (
        output start, base_addr, count, ram_data,
        input  ram_addr, busy, done, sum, max_val, ovf
    );

    modport slave (
        input  start, base_addr, count, ram_data,
        output ram_addr, busy, done, sum, max_val, ovf
    );
endinterface

// File: rtl/ram_sum_ctrl_sum_acc.sv
// Registered accumulator: modular sum, sticky carry and running maximum.
// clear wins over enable so a new run always starts from zero.
module ram_sum_ctrl_sum_acc
    import ram_sum_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] max_o,
    output logic             ovf_o
);
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   add_w;

    assign add_w = {1'b0, sum_q} + {1'b0, data_i};

    // Next accumulator values: clear, accumulate one word, or hold.
    always_comb begin
        sum_d = sum_q;
        max_d = max_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            sum_d = '0;
            max_d = '0;
            ovf_d = 1'b0;
        end else if (enable_i) begin
            sum_d = add_w[WIDTH-1:0];
            ovf_d = ovf_q | add_w[WIDTH];
            if (data_i > max_q) begin
                max_d = data_i;
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            max_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            max_q <= max_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum_o = sum_q;
    assign max_o = max_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/ram_sum_ctrl.sv
// Walks count words from base_addr through a combinational RAM,
// accumulating sum and maximum, then pulses done for one cycle.
module ram_sum_ctrl
    import ram_sum_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_sum_ctrl_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             acc_clear;
    logic             acc_en;

    // Next state, pointer and remaining-word counter.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_clear = 1'b1;
                    ptr_d     = bus.base_addr;
                    rem_d     = bus.count;
                    state_d   = (bus.count != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                acc_en = 1'b1;
                ptr_d  = ptr_q + WIDTH'(1);
                rem_d  = rem_q - WIDTH'(1);
                if (rem_q == WIDTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

    ram_sum_ctrl_sum_acc #(
        .WIDTH (WIDTH)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (acc_clear),
        .enable_i (acc_en),
        .data_i   (bus.ram_data),
        .sum_o    (bus.sum),
        .max_o    (bus.max_val),
        .ovf_o    (bus.ovf)
    );

    assign bus.ram_addr = ptr_q;
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_ram_sum_ctrl.sv
// Scoreboard bench for ram_sum_ctrl with an 8-bit behavioural RAM.
// Expected results come from a plain arithmetic model over the RAM array.
module tb_ram_sum_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic [W-1:0] mx;
        logic [W-1:0] addr;
        logic         ovf;
        int           n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] mem [256];
    exp_t sb [$];
    int checks = 0;
    int failures = 0;
    int bcnt = 0;

    ram_sum_ctrl_if #(.WIDTH(W)) bus ();

    ram_sum_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.ram_data = mem[bus.ram_addr];

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    function automatic exp_t model(int base, int cnt);
        exp_t e;
        int acc = 0;
        int mx = 0;
        bit ov = 0;
        for (int k = 0; k < cnt; k++) begin
            int w = int'(mem[(base + k) % 256]);
            if (acc + w > 255) ov = 1;
            acc = (acc + w) % 256;
            if (w > mx) mx = w;
        end
        e.sum  = W'(acc);
        e.mx   = W'(mx);
        e.ovf  = ov;
        e.addr = W'((base + cnt) % 256);
        e.n    = cnt;
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt = 0;
            end else begin
                if (bus.busy) bcnt++;
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done sum=%0h", bus.sum);
                    end else begin
                        e = sb.pop_front();
                        chk("sum", 32'(bus.sum), 32'(e.sum));
                        chk("max_val", 32'(bus.max_val), 32'(e.mx));
                        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
                        chk("end_addr", 32'(bus.ram_addr), 32'(e.addr));
                        chk("busy_cycles", 32'(bcnt), 32'(e.n));
                        chk("busy_in_done", 32'(bus.busy), 32'(0));
                    end
                    bcnt = 0;
                end
            end
        end
    end

    task automatic run(input int base, input int cnt, output exp_t e);
        bit found = 0;
        e = model(base, cnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = W'(base);
        bus.count     = W'(cnt);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 0; k <= cnt + 10; k++) begin
            @(negedge clk);
            if (bus.busy) begin
                chk("ram_addr_run", 32'(bus.ram_addr), 32'((base + k) % 256));
            end
            if (bus.done) begin
                chk("latency", 32'(k), 32'(cnt));
                found = 1;
                break;
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL done_timeout base=%0h count=%0d", base, cnt);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(0));
        chk({tag, "_max"}, 32'(bus.max_val), 32'(0));
        chk({tag, "_addr"}, 32'(bus.ram_addr), 32'(0));
        chk({tag, "_flags"}, {29'd0, bus.ovf, bus.busy, bus.done}, 32'(0));
    endtask

    initial begin
        exp_t e;
        exp_t e1;
        for (int i = 0; i < 256; i++) mem[i] = W'($urandom);
        for (int i = 0; i < 8; i++) mem[i] = W'(i + 1);
        mem[8'hFE] = 8'h80;
        mem[8'hFF] = 8'h90;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.count     = '0;

        #3;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 4, e);
        run(0, 0, e);
        run(8'hFE, 2, e);

        // start held high: one run every four cycles, nothing queued
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = 8'h00;
        bus.count     = 8'd2;
        for (int i = 0; i < 3; i++) sb.push_back(model(0, 2));
        repeat (12) @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        chk("held_start_runs", 32'(sb.size()), 32'(0));

        // asynchronous reset in the middle of a run
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = 8'h00;
        bus.count     = 8'd8;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("mid_busy", 32'(bus.busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 8, e);

        // back-to-back: result held until the next start clears it
        run(4, 2, e1);
        repeat (3) @(posedge clk);
        #1;
        chk("held_sum", 32'(bus.sum), 32'(e1.sum));
        chk("held_max", 32'(bus.max_val), 32'(e1.mx));
        run(0, 1, e);

        for (int i = 0; i < 12; i++) begin
            run(int'($urandom_range(0, 255)), int'($urandom_range(0, 12)), e);
        end

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_sum_ctrl.md
Name: ram_sum_ctrl

Overview:
- Controller and datapath that sits directly upstream of the combinational RAM: it drives the RAM address and consumes the returned data word.
- On a start pulse it walks a block of `count` consecutive words beginning at `base_addr`.
- It accumulates the unsigned sum and the maximum word, then raises `done` for one cycle.
- This is the lab datapath/FSM stage that sits around the RAM.

Parameters:
- WIDTH, 32, data and address width. Must equal the RAM's WIDTH; the RAM is combinational, `data = ram[addr]`.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- base_addr  in  WIDTH  first word address; latched on an accepted start.
- count  in  WIDTH  number of words to process; latched on an accepted start.
- ram_addr  out  WIDTH  address to the RAM; driven directly from the pointer register.
- ram_data  in  WIDTH  RAM read data; combinational from ram_addr, valid in the same cycle.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.
- sum  out  WIDTH  unsigned sum modulo 2^WIDTH; held until the next accepted start.
- max_val  out  WIDTH  largest unsigned word seen; 0 if count==0.
- ovf  out  1  sticky flag: some addition produced a carry out of bit WIDTH-1.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low (ports clk, rst_n).
  - While rst_n=0: state=IDLE; ram_addr, remaining, sum, max_val = 0; ovf, busy, done = 0.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state; nothing is combinational from inputs.
- IDLE:
  - start=1 at an edge: ptr<=base_addr, remaining<=count, sum<=0, max_val<=0, ovf<=0.
  - Next state is RUN if count!=0, else DONE.
  - start=0: hold all registers.
- RUN (busy=1), at each edge:
  - sum<=sum+ram_data; the carry ORs into ovf.
  - max_val<=max(max_val, ram_data).
  - ptr<=ptr+1; remaining<=remaining-1.
  - Leave for DONE when remaining==1 at that edge.
- DONE (done=1, busy=0): exactly one cycle, then unconditional return to IDLE.
- start in RUN or DONE is ignored; it is not queued.
- Latency:
  - start sampled at edge E0 → done is high for the cycle after edge E0+N (N=count).
  - For N=0, done is high for the cycle after E0.
  - Throughput is one word per cycle.
- ram_addr during RUN equals base_addr+k for word k.
- ram_addr after completion holds base_addr+N, wrapped modulo 2^WIDTH.
- Address wrap: ptr increments modulo 2^WIDTH. base_addr=2^WIDTH-1 with count=2 reads word 2^WIDTH-1, then word 0.
- sum and max_val are stable and valid from the done cycle until the next accepted start.
- Reset asserted mid-RUN:
  - Immediate return to the reset values.
  - No done pulse.
  - The partial sum is discarded.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE} (2-bit encoding);
  - default WIDTH constant.
- One natural sub-module, sum_acc:
  - registered adder with sticky carry and max comparator;
  - inputs: clear, enable, ram_data;
  - outputs: sum, max_val, ovf.
  - Instantiated once; the FSM, pointer and remaining counter stay in ram_sum_ctrl.

Test Plan (bench instantiates ram with WIDTH=8 and its own ram_init.txt, words 0..7 = 01 02 03 04 05 06 07 08, 0xFE=0x80, 0xFF=0x90):
- base=0, count=4, start one cycle:
  - busy high 4 cycles, done pulse on the 5th edge-cycle after the start edge;
  - sum=0x0A, max_val=0x04, ovf=0, ram_addr ends at 0x04.
- count=0, start: done the cycle after start; busy never high; sum=0, max_val=0, ovf=0.
- base=0xFE, count=2:
  - reads 0x80 then 0x90, wrapping ram_addr 0xFE→0xFF→0x00;
  - sum=0x10, max_val=0x90, ovf=1.
- start held high continuously with base=0, count=2:
  - exactly one done every 4 cycles (start, RUN×2, DONE, back to IDLE);
  - sum=0x03 each time;
  - start pulses during RUN/DONE cause no extra runs.
- base=0, count=8, rst_n dropped asynchronously mid-RUN (between edges, after 3 words):
  - outputs go to 0 immediately, no done;
  - a restart with count=8 gives sum=0x24, max_val=0x08.
- Back-to-back runs (base=4, count=2, then base=0, count=1):
  - second run shows sum=0x01, max_val=0x01, ovf=0, proving clear on start;
  - the first run's sum=0x0B is held until the second start.
